// File: rtl/rx_int_pkg.sv
// Shared definitions for the Rx interrupt generator.
// Provides the one-hot FSM state encoding (5 bits) and the default width
// of the coalescing timer.
package rx_int_pkg;

  localparam int TIMER_W_DEFAULT = 16;

  typedef logic [4:0] rx_int_state_t;

  localparam logic [4:0] ST_DISARMED = 5'b00001;
  localparam logic [4:0] ST_ARMED    = 5'b00010;
  localparam logic [4:0] ST_COALESCE = 5'b00100;
  localparam logic [4:0] ST_REQ      = 5'b01000;
  localparam logic [4:0] ST_WAIT_ACK = 5'b10000;

endpackage

// File: rtl/int_coalesce_timer.sv
// Saturating up-counter for the interrupt coalescing window.
// Ports:
//   clk, reset  : core clock, synchronous active-high reset
//   clear       : force the count to zero (wins over enable)
//   enable      : advance the count by one, holding at the maximum value
//   timeout     : window length in cycles
//   expired     : count >= timeout
module int_coalesce_timer
  import rx_int_pkg::*;
#(
  parameter int TIMER_W = TIMER_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] timeout,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != {TIMER_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= timeout);

endmodule

// File: rtl/rx_interrupt_gen.sv
// Receive-path interrupt generator with moderation.
// Raises one MSI through the PCIe cfg_interrupt handshake whenever the Rx
// ring holds unconsumed data (hw_pointer != sw_pointer), optionally after a
// coalescing window, then stays disarmed until the driver pulses notify_ack.
// Optional feature: define RX_INT_COALESCE_EN to build the coalescing timer
// and COALESCE state; without it a pending ring raises the request directly.
// Ports:
//   clk, reset          : core clock, synchronous active-high reset
//   hw_pointer          : Rx ring write pointer (DMA engine)
//   sw_pointer          : Rx ring read pointer (host)
//   notify_ack          : single-cycle re-arm pulse from the host
//   coalesce_timeout    : coalescing window in cycles
//   msi_enable          : cfg_interrupt_msienable from the PCIe core
//   cfg_interrupt_n     : active-low interrupt request (registered)
//   cfg_interrupt_rdy_n : active-low grant from the PCIe core
//   interrupt_count     : number of completed interrupts, wraps at 2^32
module rx_interrupt_gen
  import rx_int_pkg::*;
#(
  parameter int TIMER_W = TIMER_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        hw_pointer,
  input  logic [63:0]        sw_pointer,
  input  logic               notify_ack,
  input  logic [TIMER_W-1:0] coalesce_timeout,
  input  logic               msi_enable,
  output logic               cfg_interrupt_n,
  input  logic               cfg_interrupt_rdy_n,
  output logic [31:0]        interrupt_count
);

  logic [4:0] state;
  logic [4:0] state_nxt;
  logic       pending_q;
  logic       grant;

  // Plain inequality: any difference between the pointers means data waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= (hw_pointer != sw_pointer);
    end
  end

  assign grant = (state == ST_REQ) && !cfg_interrupt_rdy_n;

`ifdef RX_INT_COALESCE_EN
  logic timer_expired;

  // The timer sits at zero outside COALESCE, so entering the state starts
  // a fresh window with no explicit clear pulse.
  int_coalesce_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_COALESCE),
    .enable  (state == ST_COALESCE),
    .timeout (coalesce_timeout),
    .expired (timer_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^coalesce_timeout;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISARMED: begin
        if (notify_ack) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (pending_q && msi_enable) begin
`ifdef RX_INT_COALESCE_EN
          state_nxt = ST_COALESCE;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
`ifdef RX_INT_COALESCE_EN
      ST_COALESCE: begin
        // Host drained the ring inside the window: no interrupt needed.
        if (!pending_q) begin
          state_nxt = ST_ARMED;
        end else if (timer_expired && msi_enable) begin
          state_nxt = ST_REQ;
        end
      end
`endif
      // Once requested, the handshake always completes regardless of
      // pending_q or msi_enable.
      ST_REQ: begin
        if (!cfg_interrupt_rdy_n) state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (notify_ack) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_DISARMED;
    endcase
  end

  // Request is registered from the next state so it is low exactly while
  // the FSM sits in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_DISARMED;
      cfg_interrupt_n <= 1'b1;
      interrupt_count <= '0;
    end else begin
      state           <= state_nxt;
      cfg_interrupt_n <= (state_nxt != ST_REQ);
      if (grant) interrupt_count <= interrupt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rx_interrupt_gen.sv
module tb_rx_interrupt_gen;
  import rx_int_pkg::*;

`ifdef RX_INT_COALESCE_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] hw_pointer = '0;
  logic [63:0] sw_pointer = '0;
  logic        notify_ack = 1'b0;
  logic [15:0] coalesce_timeout = '0;
  logic        msi_enable = 1'b1;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_rdy_n = 1'b1;
  logic [31:0] interrupt_count;

  int tests = 0;
  int fails = 0;

  rx_interrupt_gen #(.TIMER_W(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .hw_pointer          (hw_pointer),
    .sw_pointer          (sw_pointer),
    .notify_ack          (notify_ack),
    .coalesce_timeout    (coalesce_timeout),
    .msi_enable          (msi_enable),
    .cfg_interrupt_n     (cfg_interrupt_n),
    .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
    .interrupt_count     (interrupt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] hw;
    logic [63:0] sw;
    logic        ack;
    logic        msi;
    logic        rdy_n;
    logic        exp_n;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic rst, logic [63:0] hw, logic [63:0] sw, logic ack,
                              logic msi, logic rdy_n, logic exp_n, logic [31:0] exp_cnt);
    vec_t v;
    v.rst = rst; v.hw = hw; v.sw = sw; v.ack = ack; v.msi = msi;
    v.rdy_n = rdy_n; v.exp_n = exp_n; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; notify_ack = 1'b0; hw_pointer = '0; sw_pointer = '0;
    msi_enable = 1'b1; cfg_interrupt_rdy_n = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic arm();
    notify_ack = 1'b1;
    tick();
    notify_ack = 1'b0;
  endtask

  // Returns the number of edges until cfg_interrupt_n is seen low, -1 on timeout.
  task automatic wait_low(input int budget, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      if (!found) begin
        tick();
        if (!cfg_interrupt_n) begin
          found = 1'b1;
          n = i;
        end
      end
    end
  endtask

  // Grant after `lat` further edges; returns total cycles the request was low.
  task automatic grant_after(input int lat, output int lowc);
    lowc = 1;
    repeat (lat) begin
      tick();
      if (!cfg_interrupt_n) lowc++;
    end
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    if (!cfg_interrupt_n) lowc++;
    cfg_interrupt_rdy_n = 1'b1;
  endtask

  // Behavioural reference: tracks whether the driver has re-armed, the age
  // of an open coalescing window (-1 when none) and an outstanding request.
  bit          m_armed, m_req, m_pend;
  int          m_age;
  logic [31:0] m_cnt;

  task automatic model_step(input int t);
    bit new_pend;
    new_pend = (hw_pointer != sw_pointer);
    if (reset) begin
      m_armed = 0; m_req = 0; m_age = -1; m_cnt = 0; new_pend = 0;
    end else if (m_req) begin
      if (!cfg_interrupt_rdy_n) begin
        m_req = 0; m_armed = 0; m_cnt = m_cnt + 1;
      end
    end else if (!m_armed) begin
      if (notify_ack) m_armed = 1;
    end else if (m_age < 0) begin
      if (m_pend && msi_enable) begin
        if (CO) m_age = 0;
        else m_req = 1;
      end
    end else if (!m_pend) begin
      m_age = -1;
    end else if (m_age >= t && msi_enable) begin
      m_req = 1; m_age = -1;
    end else if (m_age < 65535) begin
      m_age++;
    end
    m_pend = new_pend;
  endtask

  initial begin
    int n, lowc, t;
    logic [63:0] pool[4];
    logic [63:0] hb, hb1;
    hb  = 64'h8000_0000_0000_0000;
    hb1 = 64'h8000_0000_0000_0001;

    // ---------------- table-driven vectors (timeout 0) ----------------
    coalesce_timeout = 16'd0;
    tbl[0]  = mk(1, 0,  0,  0, 1, 1, 1, 0);
    tbl[1]  = mk(0, 0,  0,  0, 1, 1, 1, 0);
    tbl[2]  = mk(0, hb, 0,  0, 1, 1, 1, 0);
    tbl[3]  = mk(0, hb, 0,  0, 1, 1, 1, 0);
    tbl[4]  = mk(0, hb, 0,  1, 1, 1, 1, 0);
    tbl[5]  = mk(0, hb, 0,  0, 0, 1, 1, 0);
    tbl[6]  = mk(0, hb, 0,  0, 0, 1, 1, 0);
    tbl[7]  = mk(0, hb, 0,  0, 1, 1, CO ? 1'b1 : 1'b0, 0);
    tbl[8]  = mk(0, hb, 0,  0, 1, 0, CO ? 1'b0 : 1'b1, CO ? 32'd0 : 32'd1);
    tbl[9]  = mk(0, hb, 0,  0, 1, 0, 1, 1);
    tbl[10] = mk(0, hb, hb, 1, 1, 1, 1, 1);
    tbl[11] = mk(0, hb, hb, 0, 1, 1, 1, 1);
    tbl[12] = mk(0, hb, hb, 0, 1, 1, 1, 1);
    tbl[13] = mk(0, hb1, hb, 0, 1, 1, 1, 1);
    tbl[14] = mk(0, hb1, hb, 0, 1, 1, CO ? 1'b1 : 1'b0, 1);
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; hw_pointer = tbl[i].hw; sw_pointer = tbl[i].sw;
      notify_ack = tbl[i].ack; msi_enable = tbl[i].msi; cfg_interrupt_rdy_n = tbl[i].rdy_n;
      tick();
      chk($sformatf("tbl%0d_int_n", i), {63'd0, cfg_interrupt_n}, {63'd0, tbl[i].exp_n});
      chk($sformatf("tbl%0d_count", i), {32'd0, interrupt_count}, {32'd0, tbl[i].exp_cnt});
    end

    // ---------------- reset values ----------------
    coalesce_timeout = 16'd10;
    do_reset();
    chk("reset_int_n", {63'd0, cfg_interrupt_n}, 64'd1);
    chk("reset_count", {32'd0, interrupt_count}, 64'd0);
    chk("reset_state", {59'd0, dut.state}, {59'd0, ST_DISARMED});

`ifdef RX_INT_COALESCE_EN
    // ---------------- window of 10, grant latency 3 ----------------
    arm();
    hw_pointer = 64'h40;
    wait_low(100, n);
    chk("first_req_latency", n, 13);
    grant_after(3, lowc);
    chk("req_low_cycles", lowc, 4);
    chk("first_count", {32'd0, interrupt_count}, 64'd1);
    chk("wait_ack_state", {59'd0, dut.state}, {59'd0, ST_WAIT_ACK});

    // no second request without ack
    hw_pointer = 64'h80;
    lowc = 0;
    repeat (1000) begin
      tick();
      if (!cfg_interrupt_n) lowc++;
    end
    chk("no_req_without_ack", lowc, 0);
    sw_pointer = 64'h40;
    arm();
    wait_low(100, n);
    chk("rearm_req_latency", n, 12);
    grant_after(0, lowc);
    chk("second_count", {32'd0, interrupt_count}, 64'd2);

    // ---------------- host drains inside the window ----------------
    do_reset();
    arm();
    hw_pointer = 64'h40;
    repeat (6) tick();
    sw_pointer = 64'h40;
    lowc = 0;
    repeat (30) begin
      tick();
      if (!cfg_interrupt_n) lowc++;
    end
    chk("drain_no_req", lowc, 0);
    chk("drain_state", {59'd0, dut.state}, {59'd0, ST_ARMED});
    chk("drain_count", {32'd0, interrupt_count}, 64'd0);

    // ---------------- msi_enable low inside the window ----------------
    coalesce_timeout = 16'd5;
    do_reset();
    arm();
    hw_pointer = 64'h40;
    tick(); tick();
    msi_enable = 1'b0;
    lowc = 0;
    repeat (100) begin
      tick();
      if (!cfg_interrupt_n) lowc++;
    end
    chk("msi_off_no_req", lowc, 0);
    msi_enable = 1'b1;
    wait_low(2, n);
    chk("msi_on_req_found", {63'd0, n > 0}, 64'd1);
    grant_after(0, lowc);
    chk("msi_count", {32'd0, interrupt_count}, 64'd1);
    coalesce_timeout = 16'd10;
`endif

    // ---------------- request latency and reset mid-request ----------------
    do_reset();
    arm();
    hw_pointer = 64'h40;
    wait_low(100, n);
    chk("req_latency", n, CO ? 13 : 2);
    reset = 1'b1;
    tick();
    chk("rst_mid_req_int_n", {63'd0, cfg_interrupt_n}, 64'd1);
    chk("rst_mid_req_count", {32'd0, interrupt_count}, 64'd0);
    chk("rst_mid_req_state", {59'd0, dut.state}, {59'd0, ST_DISARMED});
    reset = 1'b0;

    // ---------------- counter wrap ----------------
    do_reset();
    arm();
    hw_pointer = 64'h40;
    wait_low(100, n);
    chk("wrap_req_found", {63'd0, n > 0}, 64'd1);
    force dut.interrupt_count = 32'hFFFF_FFFF;
    #1;
    release dut.interrupt_count;
    grant_after(0, lowc);
    chk("count_wrap", {32'd0, interrupt_count}, 64'd0);

    // ---------------- randomized run against the reference ----------------
    pool[0] = 64'h0; pool[1] = 64'h40; pool[2] = hb; pool[3] = 64'h8000_0000_0000_0040;
    t = $urandom_range(0, 6);
    coalesce_timeout = t[15:0];
    reset = 1'b1;
    model_step(t);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) hw_pointer = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) sw_pointer = pool[$urandom_range(0, 3)];
      notify_ack = ($urandom_range(0, 9) == 0);
      msi_enable = ($urandom_range(0, 9) != 0);
      cfg_interrupt_rdy_n = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 499) == 0);
      model_step(t);
      tick();
      chk($sformatf("rand%0d", c), {31'd0, cfg_interrupt_n, interrupt_count},
          {31'd0, !m_req, m_cnt});
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
